// File: rtl/count_bcd_display_if.sv
// Valid/ready channel carrying a binary count into the BCD display stage.
// The producer drives value and valid; the display stage answers with ready.
interface count_bcd_display_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] bin_in;

    modport master (
        output in_valid,
        output bin_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  bin_in,
        output in_ready
    );
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (iterative shift-add-3) feeding a time-multiplexed
// 7-segment scanner with optional leading-zero blanking.
module count_bcd_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    count_bcd_display_if.slave    in_if,
    input  logic                  blank_lz,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  dig_en_q, dig_en_d;

    logic [ACC_W-1:0]   adj_s;
    logic [ACC_W-1:0]   acc_shift_s;
    logic [3:0]         digit_s;
    logic               blank_s;
    logic               upper_nz_s;

    // Every BCD digit of 5 or more gets +3 so the following shift carries correctly.
    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Ready is gated by reset so a producer never sees a handshake while held in reset.
    assign in_if.in_ready = (state_q == ST_IDLE) && !rst;
    assign done           = done_q;
    assign bcd_out        = bcd_q;
    assign seg            = seg_q;
    assign dig_en         = dig_en_q;

    // Conversion FSM: capture in IDLE, one add-3/shift step per SHIFT cycle.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        done_d      = 1'b0;
        adj_s       = add3(acc_q);
        acc_shift_s = {adj_s[ACC_W-2:0], sr_q[WIDTH-1]};
        case (state_q)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    sr_d    = in_if.bin_in;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shift_s;
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bcd_d   = acc_shift_s;
                    done_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display scan: refresh divider, digit index, and the segment pattern for the next index.
    always_comb begin
        ref_d      = ref_q;
        idx_d      = idx_q;
        dig_en_d   = {DIGITS{1'b0}};
        digit_s    = 4'd0;
        blank_s    = 1'b0;
        upper_nz_s = 1'b0;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = {REF_W{1'b0}};
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            ref_d = ref_q + REF_W'(1);
            idx_d = idx_q;
        end
        dig_en_d[idx_d] = 1'b1;
        // Walk from the most significant digit down so upper_nz_s covers "this digit and above".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_nz_s = upper_nz_s | (bcd_q[4*i +: 4] != 4'd0);
            if (idx_d == IDX_W'(i)) begin
                digit_s = bcd_q[4*i +: 4];
                blank_s = blank_lz && (i != 0) && !upper_nz_s;
            end else begin
                digit_s = digit_s;
                blank_s = blank_s;
            end
        end
        if (blank_s) begin
            seg_d = 7'h00;
        end else begin
            seg_d = seg_enc(digit_s);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sr_q     <= {WIDTH{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            bcd_q    <= {ACC_W{1'b0}};
            done_q   <= 1'b0;
            ref_q    <= {REF_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            seg_q    <= 7'h3F;
            dig_en_q <= {{(DIGITS-1){1'b0}}, 1'b1};
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            done_q   <= done_d;
            ref_q    <= ref_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
        end
    end

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Downstream display stage for the 8-bit counter. Accepts a binary count over a valid/ready handshake and converts it to packed BCD with an iterative shift-add-3 (double-dabble) engine. Holds the result and drives a time-multiplexed, common-anode-agnostic 7-segment display with optional leading-zero blanking. Sits between the counter's `uo_out` count value and the chip's segment and digit-select pins.

## Interface

**Parameters**
- `WIDTH`, default 8: binary input width. Supported range 4..16.
- `DIGITS`, default 3: number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `REFRESH_DIV`, default 1024: clock cycles each digit stays lit. Must be ≥ 2.

**Ports** (clock and reset first)
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `bin_in` is valid.
- `in_ready`  out  1: block can accept; high only in IDLE and only while `rst` is low.
- `bin_in`  in  WIDTH: binary value to convert.
- `blank_lz`  in  1: when 1, blank leading zero digits.
- `done`  out  1: one-cycle pulse; `bcd_out` has just updated.
- `bcd_out`  out  4*DIGITS: packed BCD; digit 0 (units) is in bits [3:0].
- `seg`  out  7: active-high segments, ordered {g,f,e,d,c,b,a}.
- `dig_en`  out  DIGITS: one-hot enable of the lit digit; bit 0 is units.

## Operation

- **FSM states.** IDLE → SHIFT → IDLE.
  - IDLE: `in_ready`=1. If `in_valid` is high at an edge, capture `bin_in` into a shift register, clear the BCD accumulator, set the iteration counter to 0, and go to SHIFT.
  - SHIFT: each cycle, every accumulator digit ≥5 gets +3. Then {accumulator, shift register} shifts left by 1. Counter increments.
  - After the WIDTH-th shift, load `bcd_out` from the accumulator, pulse `done`, and return to IDLE.
- **Inputs during SHIFT.** `in_valid` and `bin_in` are ignored. Only the value captured at acceptance is converted.
- **Accumulator width.** The accumulator is 4*DIGITS bits. The parameter constraint guarantees no overflow.
- **Result holding.** `bcd_out` holds its value until the next conversion completes. The display always shows `bcd_out`, never intermediate accumulator contents.
- **Refresh counter.** Counts 0..REFRESH_DIV−1 and wraps. On each wrap the digit index advances 0→1→…→DIGITS−1→0.
- **Digit enable.** `dig_en` = one-hot of the digit index.
- **Segment encoding.** `seg` = encode(selected digit):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Any value >9 (unreachable) encodes to 0x00.
- **Leading-zero blanking.** When `blank_lz`=1, digit i (i>0) outputs `seg`=0x00 if it and all higher digits are zero. Units are never blanked. `dig_en` still scans normally.
- **`seg` and `dig_en` timing.** Both are registered and change together on the same edge.

## Timing

- **Reset values (while `rst` high and on the first edge after).**
  - FSM=IDLE, `in_ready`=0 while `rst`=1.
  - `done`=0, `bcd_out`=0.
  - Refresh counter=0, digit index=0, `dig_en`=…001, `seg`=0x3F.
- **Latency.** Acceptance at edge E0 → `bcd_out` updated and `done`=1 at edge E0+WIDTH. `done` drops at E0+WIDTH+1.
- **Ready timing.** `in_ready` is low from E0 through E0+WIDTH and high again in the cycle following edge E0+WIDTH (the same cycle `done` is high).
- **Throughput.** The earliest next acceptance is edge E0+WIDTH+1, so one conversion per WIDTH+1 cycles.
- **Display lag.** The segment display reflects the new `bcd_out` at the next display register update, at most one cycle after `done`.
- **Reset mid-conversion.** Aborts the conversion. All state returns to reset values, `done` is not pulsed, and `bcd_out`=0.
- **Simultaneous `in_valid` and `done`.** `in_valid` in the `done` cycle is accepted at the next edge (IDLE, ready=1).
- **Refresh wrap.** The digit index changes on the edge where the refresh counter goes from REFRESH_DIV−1 to 0.

## Test plan

- **Reset values.** Hold `rst` 3 cycles → `in_ready`=0 during reset; after release `in_ready`=1, `bcd_out`=0x000, `done`=0, `dig_en`=3'b001, `seg`=0x3F.
- **Full-scale conversion.** `bin_in`=255, `in_valid` 1 cycle accepted at E0 → `done`=1 exactly at E0+8, `bcd_out`=0x255, `in_ready` low for edges E0..E0+8.
- **Back-to-back conversions.** `in_valid` held high with 9 then 10 → `bcd_out`=0x009 then 0x010. Second acceptance at E0+9, second `done` at E0+17. Changing `bin_in` mid-SHIFT does not alter results.
- **Display scan and blanking.** REFRESH_DIV=4, `bcd_out`=0x007, `blank_lz`=1 → `dig_en` cycles 001→010→100 every 4 cycles with `seg` 0x07, 0x00, 0x00. With `blank_lz`=0 → `seg` 0x07, 0x3F, 0x3F. For 0x105, blank_lz=1 → `seg` 0x6D, 0x3F, 0x06 (inner zero shown).
- **Reset mid-conversion.** `bin_in`=200, assert `rst` at E0+4 → no `done` pulse, `bcd_out`=0x000. After release, a new conversion of 200 gives 0x200.
- **Exhaustive sweep.** All values 0..255 → `bcd_out` matches the decimal reference for each value, and every `done` arrives exactly 8 cycles after acceptance.
